// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: default widths and FSM state encoding.
package glitch_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int N_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_FIRE  = 3'd3,
    S_PULSE = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/duration_counter.sv
// Pulse timer: on enable, drives active_low low for din+1 cycles.
module duration_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] din,
  output logic         active_low
);

  logic         active;
  logic [W-1:0] count;

  // The count runs din..0 while active, giving din+1 low cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      count  <= '0;
    end else if (enable) begin
      active <= 1'b1;
      count  <= din;
    end else if (active) begin
      if (count != '0) count <= count - W'(1);
      else             active <= 1'b0;
    end
  end

  assign active_low = ~active;

endmodule

// File: rtl/glitch_sequencer.sv
// Glitch scheduler: arms, waits for a trigger edge, delays, then fires a burst
// of active-low pulses timed by a duration_counter.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int N_W   = N_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [N_W-1:0]   cfg_count,
  output logic             glitch_n,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   pulse_idx
);

  state_t           state, next_state;
  logic             trigger_d;
  logic             trig_edge;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] delay_lat;
  logic [CNT_W-1:0] width_m1;
  logic [CNT_W-1:0] gap_lat;
  logic [N_W-1:0]   remaining;
  logic             dc_enable;

  assign trig_edge = trigger & ~trigger_d;
  assign dc_enable = (state == S_FIRE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:         if (arm) next_state = S_ARMED;
      S_ARMED:        if (trig_edge) next_state = S_DELAY;
      S_DELAY, S_GAP: if (cnt == '0) next_state = S_FIRE;
      S_FIRE:         next_state = S_PULSE;
      S_PULSE:        if (glitch_n) next_state = (remaining > N_W'(1)) ? S_GAP : S_DONE;
      S_DONE:         next_state = S_IDLE;
      default:        next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // Datapath follows the FSM; abort freezes it so pulse_idx survives an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      trigger_d <= 1'b1;
      cnt       <= '0;
      delay_lat <= '0;
      width_m1  <= '0;
      gap_lat   <= '0;
      remaining <= '0;
      pulse_idx <= '0;
    end else begin
      trigger_d <= trigger;
      if (!abort) begin
        case (state)
          S_IDLE: if (arm) begin
            delay_lat <= cfg_delay;
            width_m1  <= (cfg_width == '0) ? '0 : cfg_width - CNT_W'(1);
            gap_lat   <= cfg_gap;
            remaining <= (cfg_count == '0) ? N_W'(1) : cfg_count;
            pulse_idx <= '0;
          end
          S_ARMED: if (trig_edge) cnt <= delay_lat;
          S_DELAY, S_GAP: if (cnt != '0) cnt <= cnt - CNT_W'(1);
          S_FIRE: pulse_idx <= pulse_idx + N_W'(1);
          S_PULSE: if (glitch_n && remaining > N_W'(1)) begin
            remaining <= remaining - N_W'(1);
            cnt       <= gap_lat;
          end
          default: ;
        endcase
      end
    end
  end

  duration_counter #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset | abort),
    .enable     (dc_enable),
    .din        (width_m1),
    .active_low (glitch_n)
  );

  assign armed = (state == S_ARMED);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: a per-cycle scoreboard of
// expected glitch_n/done/busy built from an independent timing model.
module tb_glitch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] cfg_delay = '0;
  logic [31:0] cfg_width = '0;
  logic [31:0] cfg_gap = '0;
  logic [7:0]  cfg_count = '0;
  logic        glitch_n, armed, busy, done;
  logic [7:0]  pulse_idx;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic g;
    logic d;
    logic b;
    int   j;
  } exp_t;
  exp_t sb[$];

  glitch_sequencer #(.CNT_W(32), .N_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .abort     (abort),
    .trigger   (trigger),
    .cfg_delay (cfg_delay),
    .cfg_width (cfg_width),
    .cfg_gap   (cfg_gap),
    .cfg_count (cfg_count),
    .glitch_n  (glitch_n),
    .armed     (armed),
    .busy      (busy),
    .done      (done),
    .pulse_idx (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input int d, input int w, input int g, input int n);
    cfg_delay = d;
    cfg_width = w;
    cfg_gap   = g;
    cfg_count = 8'(n);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Sample j is taken just after edge E0+j, E0 being the edge that sees the trigger rise.
  task automatic push_burst(input int d, input int w, input int g, input int n, input int jmax);
    int ew, en, per, last_low;
    exp_t e;
    ew = (w == 0) ? 1 : w;
    en = (n == 0) ? 1 : n;
    per = ew + g + 3;
    last_low = d + 1 + ew + (en - 1) * per;
    for (int j = 0; j <= last_low + 3 && j <= jmax; j++) begin
      e.g = 1'b1;
      for (int k = 0; k < en; k++) begin
        if (j >= d + 2 + k * per && j < d + 2 + k * per + ew) e.g = 1'b0;
      end
      e.d = (j == last_low + 2);
      e.b = (j <= last_low + 2);
      e.j = j;
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input int cycles);
    exp_t e;
    for (int j = 0; j < cycles; j++) begin
      e.g = 1'b1;
      e.d = 1'b0;
      e.b = 1'b0;
      e.j = j;
      sb.push_back(e);
    end
  endtask

  task automatic drain_n(input string name, input int cycles);
    exp_t e;
    int left;
    left = cycles;
    while (left > 0 && sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      total++;
      if ({glitch_n, done, busy} !== {e.g, e.d, e.b}) begin
        bad++;
        $display("[TB] FAIL %s j=%0d got g/d/b=%b%b%b want %b%b%b",
                 name, e.j, glitch_n, done, busy, e.g, e.d, e.b);
      end
      left--;
    end
  endtask

  task automatic check_idx(input string name, input logic [7:0] want);
    total++;
    if (pulse_idx !== want) begin
      bad++;
      $display("[TB] FAIL %s pulse_idx got %0d want %0d", name, pulse_idx, want);
    end
  endtask

  task automatic run_burst(input string name, input int d, input int w, input int g, input int n);
    arm_cfg(d, w, g, n);
    trigger = 1'b1;
    push_burst(d, w, g, n, 100000);
    drain_n(name, 100000);
    trigger = 1'b0;
    check_idx(name, 8'((n == 0) ? 1 : n));
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    trigger = 1'b1;
    tick();
    tick();
    total++;
    if ({glitch_n, armed, busy, done, pulse_idx} !== {4'b1000, 8'd0}) begin
      bad++;
      $display("[TB] FAIL reset got g/a/b/d=%b%b%b%b idx=%0d want 1000 idx=0",
               glitch_n, armed, busy, done, pulse_idx);
    end
    reset = 1'b0;
    trigger = 1'b0;
    tick();
  endtask

  task automatic test_single;
    run_burst("single", 10, 4, 0, 1);
  endtask

  task automatic test_multi;
    run_burst("multi", 0, 1, 2, 3);
  endtask

  task automatic test_clamp;
    run_burst("clamp", 3, 0, 5, 0);
  endtask

  task automatic test_trigger_held;
    exp_t e;
    trigger = 1'b1;
    arm_cfg(20, 2, 0, 1);
    for (int j = 0; j < 20; j++) begin
      e.g = 1'b1; e.d = 1'b0; e.b = 1'b1; e.j = j;
      sb.push_back(e);
    end
    drain_n("held", 20);
    total++;
    if (armed !== 1'b1) begin
      bad++;
      $display("[TB] FAIL held_armed got %b want 1", armed);
    end
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    push_burst(20, 2, 0, 1, 100000);
    drain_n("retrig", 3);
    trigger = 1'b0;
    drain_n("retrig", 2);
    trigger = 1'b1;
    drain_n("retrig", 100000);
    push_idle(6);
    drain_n("retrig_idle", 6);
    trigger = 1'b0;
    check_idx("retrig", 8'd1);
    tick();
  endtask

  task automatic test_abort;
    arm_cfg(2, 100, 0, 1);
    trigger = 1'b1;
    push_burst(2, 100, 0, 1, 5);
    drain_n("abort_pre", 100000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({glitch_n, armed, busy, done} !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL abort got g/a/b/d=%b%b%b%b want 1000", glitch_n, armed, busy, done);
    end
    check_idx("abort_keep", 8'd1);
    trigger = 1'b0;
    push_idle(5);
    drain_n("abort_idle", 5);
    abort = 1'b1;
    arm = 1'b1;
    tick();
    abort = 1'b0;
    arm = 1'b0;
    total++;
    if ({armed, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL abort_arm got a/b=%b%b want 00", armed, busy);
    end
    run_burst("after_abort", 1, 2, 1, 2);
  endtask

  task automatic test_back_to_back;
    arm_cfg(4, 3, 1, 2);
    cfg_delay = 0;
    cfg_width = 9;
    cfg_gap   = 9;
    cfg_count = 8'd5;
    trigger = 1'b1;
    push_burst(4, 3, 1, 2, 100000);
    drain_n("latched", 5);
    arm = 1'b1;
    drain_n("latched", 1);
    arm = 1'b0;
    drain_n("latched", 100000);
    trigger = 1'b0;
    check_idx("latched", 8'd2);
    tick();
    run_burst("second", 2, 1, 0, 2);
  endtask

  task automatic test_reset_gap;
    arm_cfg(1, 2, 10, 2);
    trigger = 1'b1;
    push_burst(1, 2, 10, 2, 9);
    drain_n("gap_pre", 100000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({glitch_n, armed, busy, done, pulse_idx} !== {4'b1000, 8'd0}) begin
      bad++;
      $display("[TB] FAIL reset_gap got g/a/b/d=%b%b%b%b idx=%0d want 1000 idx=0",
               glitch_n, armed, busy, done, pulse_idx);
    end
    trigger = 1'b0;
    tick();
    run_burst("after_reset", 0, 2, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_clamp();
    test_trigger_held();
    test_abort();
    test_back_to_back();
    test_reset_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
